// File: rtl/ex_stage_pkg.sv
// ---------------------------------------------------------------------------
// ex_stage_pkg
// Shared definitions for the execute stage: ALU operation codes, result-class
// selectors, common constant words, write/stall encodings and the divider
// state type. Imported by ex_stage and div_iter.
// ---------------------------------------------------------------------------
package ex_stage_pkg;

    localparam int ALUOP_W    = 8;
    localparam int ALUSEL_W   = 3;
    localparam int REG_ADDR_W = 5;

    // aluop codes (ALUOpBus)
    localparam logic [ALUOP_W-1:0] EXE_NOP_OP  = 8'b0000_0000;
    localparam logic [ALUOP_W-1:0] EXE_AND_OP  = 8'b0010_0100;
    localparam logic [ALUOP_W-1:0] EXE_OR_OP   = 8'b0010_0101;
    localparam logic [ALUOP_W-1:0] EXE_XOR_OP  = 8'b0010_0110;
    localparam logic [ALUOP_W-1:0] EXE_NOR_OP  = 8'b0010_0111;
    localparam logic [ALUOP_W-1:0] EXE_SLL_OP  = 8'b0111_1100;
    localparam logic [ALUOP_W-1:0] EXE_SRL_OP  = 8'b0000_0010;
    localparam logic [ALUOP_W-1:0] EXE_SRA_OP  = 8'b0000_0011;
    localparam logic [ALUOP_W-1:0] EXE_SLT_OP  = 8'b0010_1010;
    localparam logic [ALUOP_W-1:0] EXE_SLTU_OP = 8'b0010_1011;
    localparam logic [ALUOP_W-1:0] EXE_ADDU_OP = 8'b0010_0001;
    localparam logic [ALUOP_W-1:0] EXE_SUBU_OP = 8'b0010_0011;
    localparam logic [ALUOP_W-1:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [ALUOP_W-1:0] EXE_DIVU_OP = 8'b0001_1011;

    // alusel codes (ALUSelBus): which result class drives wdata
    localparam logic [ALUSEL_W-1:0] EXE_RES_NOP        = 3'b000;
    localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC      = 3'b001;
    localparam logic [ALUSEL_W-1:0] EXE_RES_SHIFT      = 3'b010;
    localparam logic [ALUSEL_W-1:0] EXE_RES_ARITHMETIC = 3'b100;

    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
    localparam logic        WRITE_ENABLE  = 1'b1;
    localparam logic        WRITE_DISABLE = 1'b0;
    localparam logic        STOP          = 1'b1;
    localparam logic        NO_STOP       = 1'b0;

    // Divider FSM states
    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_ZERO = 2'b01,
        DIV_ON   = 2'b10,
        DIV_END  = 2'b11
    } div_state_t;

    // True for either divide opcode (signed or unsigned)
    function automatic logic is_div_op(input logic [ALUOP_W-1:0] op);
        return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
    endfunction

endpackage

// File: rtl/ex_stage_div.sv
// ---------------------------------------------------------------------------
// div_iter
// Iterative radix-2 restoring divider, one quotient bit per clock.
//   clk, rst   clock / asynchronous active-high reset
//   start      request a divide (already qualified by the caller)
//   signed_op  1 = DIV (two's complement operands), 0 = DIVU
//   annul      abort whatever is in flight; FSM returns to IDLE next edge
//   opdata1    dividend
//   opdata2    divisor
//   result     {remainder, quotient}, valid while ready = 1
//   ready      high for exactly one cycle (END state)
//   stall      high while the divide still needs the pipeline held
// Timing: IDLE(start) -> ON x DATA_W -> END, or IDLE -> DIVZERO -> END.
// ---------------------------------------------------------------------------
module div_iter
    import ex_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                signed_op,
    input  logic                annul,
    input  logic [DATA_W-1:0]   opdata1,
    input  logic [DATA_W-1:0]   opdata2,
    output logic [2*DATA_W-1:0] result,
    output logic                ready,
    output logic                stall
);

    localparam int CNT_W = $clog2(DATA_W);

    div_state_t           state_reg;
    logic [DATA_W-1:0]    rem_reg;       // partial remainder
    logic [DATA_W-1:0]    quo_reg;       // dividend shifting out / quotient shifting in
    logic [DATA_W-1:0]    divisor_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic                 neg_quo_reg;   // quotient must be negated at the end
    logic                 neg_rem_reg;   // remainder takes the dividend's sign
    logic [2*DATA_W-1:0]  result_reg;

    // Magnitudes used for the signed case; DIVU takes operands untouched.
    // |0x80..0| is representable as an unsigned magnitude, so no overflow here.
    logic [DATA_W-1:0] op1_abs;
    logic [DATA_W-1:0] op2_abs;

    always_comb begin
        op1_abs = opdata1;
        op2_abs = opdata2;
        if (signed_op && opdata1[DATA_W-1]) begin
            op1_abs = -opdata1;
        end
        if (signed_op && opdata2[DATA_W-1]) begin
            op2_abs = -opdata2;
        end
    end

    // One restoring step: bring the next dividend bit into the remainder and
    // try to subtract the divisor. The extra top bit of diff is the borrow.
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] step_rem;
    logic [DATA_W-1:0] step_quo;
    logic [DATA_W-1:0] final_quo;
    logic [DATA_W-1:0] final_rem;

    always_comb begin
        shifted = {rem_reg, quo_reg[DATA_W-1]};
        diff    = shifted - {1'b0, divisor_reg};
        if (diff[DATA_W]) begin
            // Borrow: divisor did not fit, keep the shifted remainder
            step_rem = shifted[DATA_W-1:0];
            step_quo = {quo_reg[DATA_W-2:0], 1'b0};
        end else begin
            step_rem = diff[DATA_W-1:0];
            step_quo = {quo_reg[DATA_W-2:0], 1'b1};
        end
        // Sign correction applied to the last step's output as it is registered
        final_quo = neg_quo_reg ? -step_quo : step_quo;
        final_rem = neg_rem_reg ? -step_rem : step_rem;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= DIV_IDLE;
            rem_reg     <= '0;
            quo_reg     <= '0;
            divisor_reg <= '0;
            cnt_reg     <= '0;
            neg_quo_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            result_reg  <= '0;
        end else if (annul) begin
            state_reg <= DIV_IDLE;
        end else begin
            case (state_reg)
                DIV_IDLE: begin
                    if (start) begin
                        if (opdata2 == '0) begin
                            state_reg <= DIV_ZERO;
                        end else begin
                            state_reg   <= DIV_ON;
                            rem_reg     <= '0;
                            quo_reg     <= op1_abs;
                            divisor_reg <= op2_abs;
                            cnt_reg     <= '0;
                            neg_quo_reg <= signed_op & (opdata1[DATA_W-1] ^ opdata2[DATA_W-1]);
                            neg_rem_reg <= signed_op & opdata1[DATA_W-1];
                        end
                    end
                end
                DIV_ZERO: begin
                    result_reg <= '0;
                    state_reg  <= DIV_END;
                end
                DIV_ON: begin
                    rem_reg <= step_rem;
                    quo_reg <= step_quo;
                    if (cnt_reg == CNT_W'(DATA_W - 1)) begin
                        result_reg <= {final_rem, final_quo};
                        state_reg  <= DIV_END;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DIV_END: begin
                    state_reg <= DIV_IDLE;
                end
                default: begin
                    state_reg <= DIV_IDLE;
                end
            endcase
        end
    end

    assign result = result_reg;
    assign ready  = (state_reg == DIV_END);

    // The stall must already be up in the IDLE cycle the op arrives in,
    // hence the combinational term on start. END releases the pipeline.
    assign stall = !annul &&
                   (((state_reg == DIV_IDLE) && start) ||
                    (state_reg == DIV_ZERO) ||
                    (state_reg == DIV_ON));

endmodule

// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage
// Execute stage between ID/EX and EX/MEM. Logic, shift and arithmetic results
// are combinational; DIV/DIVU run on div_iter and hold the pipeline through
// stallreq_o until the HI/LO pair is written in the divider's END cycle.
//   clk, rst            clock / asynchronous active-high reset
//   aluop_i, alusel_i   operation code and result class from ID/EX
//   reg1_i, reg2_i      operands (reg1 supplies the shift amount)
//   wd_i, wreg_i        destination GPR and write enable
//   annul_i             flush: abort any in-flight divide
//   wd_o, wreg_o        destination / enable to EX/MEM (wreg forced 0 on divides)
//   wdata_o             GPR write data
//   whilo_o, hi_o, lo_o HI/LO write (remainder / quotient), only in END
//   stallreq_o          hold PC/IF/ID/ID-EX
// While rst is asserted every output is driven to 0.
// ---------------------------------------------------------------------------
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OP_W   = 8,
    parameter int SEL_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OP_W-1:0]   aluop_i,
    input  logic [SEL_W-1:0]  alusel_i,
    input  logic [DATA_W-1:0] reg1_i,
    input  logic [DATA_W-1:0] reg2_i,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic              annul_i,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              whilo_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              stallreq_o
);

    logic                is_div;
    logic                div_start;
    logic                div_ready;
    logic                div_stall;
    logic [2*DATA_W-1:0] div_result;

    assign is_div    = is_div_op(aluop_i);
    assign div_start = is_div && !annul_i;

    div_iter #(
        .DATA_W (DATA_W)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .signed_op (aluop_i == EXE_DIV_OP),
        .annul     (annul_i),
        .opdata1   (reg1_i),
        .opdata2   (reg2_i),
        .result    (div_result),
        .ready     (div_ready),
        .stall     (div_stall)
    );

    // ---------------- ALU result classes ----------------
    logic [DATA_W-1:0] logic_res;
    logic [DATA_W-1:0] shift_res;
    logic [DATA_W-1:0] arith_res;
    logic [4:0]        shamt;

    assign shamt = reg1_i[4:0];

    always_comb begin
        logic_res = '0;
        case (aluop_i)
            EXE_OR_OP:  logic_res = reg1_i | reg2_i;
            EXE_AND_OP: logic_res = reg1_i & reg2_i;
            EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
            EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
            default:    logic_res = '0;
        endcase
    end

    always_comb begin
        shift_res = '0;
        case (aluop_i)
            EXE_SLL_OP: shift_res = reg2_i << shamt;
            EXE_SRL_OP: shift_res = reg2_i >> shamt;
            EXE_SRA_OP: shift_res = $signed(reg2_i) >>> shamt;
            default:    shift_res = '0;
        endcase
    end

    always_comb begin
        arith_res = '0;
        case (aluop_i)
            EXE_ADDU_OP: arith_res = reg1_i + reg2_i;
            EXE_SUBU_OP: arith_res = reg1_i - reg2_i;
            EXE_SLT_OP:  arith_res = {{(DATA_W-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
            EXE_SLTU_OP: arith_res = {{(DATA_W-1){1'b0}}, (reg1_i < reg2_i)};
            default:     arith_res = '0;
        endcase
    end

    // ---------------- Output glue ----------------
    always_comb begin
        wd_o       = '0;
        wreg_o     = WRITE_DISABLE;
        wdata_o    = '0;
        whilo_o    = WRITE_DISABLE;
        hi_o       = '0;
        lo_o       = '0;
        stallreq_o = NO_STOP;
        if (!rst) begin
            wd_o   = wd_i;
            // Divides deliver through HI/LO only, never the GPR file
            wreg_o = is_div ? WRITE_DISABLE : wreg_i;
            case (alusel_i)
                EXE_RES_LOGIC:      wdata_o = logic_res;
                EXE_RES_SHIFT:      wdata_o = shift_res;
                EXE_RES_ARITHMETIC: wdata_o = arith_res;
                default:            wdata_o = '0;
            endcase
            stallreq_o = div_stall ? STOP : NO_STOP;
            // A flush landing in END suppresses the HI/LO write too
            if (div_ready && !annul_i) begin
                whilo_o = WRITE_ENABLE;
                hi_o    = div_result[2*DATA_W-1:DATA_W];
                lo_o    = div_result[DATA_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i, reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i, annul_i;
    logic [4:0]  wd_o;
    logic        wreg_o, whilo_o, stallreq_o;
    logic [31:0] wdata_o, hi_o, lo_o;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    ex_stage #(.DATA_W(32), .OP_W(8), .SEL_W(3)) dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .annul_i(annul_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [7:0]  op;
        logic [2:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  wd;
        logic        wreg;
        logic        annul;
        logic [31:0] exp_wdata;
        logic        exp_wreg;
        logic        exp_stall;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("[TB] ok %s = 0x%08h", name, act);
        end
    endtask

    task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] wd, input logic wreg,
                         input logic annul);
        aluop_i  = op;
        alusel_i = sel;
        reg1_i   = a;
        reg2_i   = b;
        wd_i     = wd;
        wreg_i   = wreg;
        annul_i  = annul;
    endtask

    // Reference ALU written from the operation definitions
    function automatic logic [31:0] model_alu(input logic [7:0] op, input logic [2:0] sel,
                                              input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        longint      sum;
        int          amt;
        r   = 32'h0;
        amt = int'(a % 32);
        if (sel == EXE_RES_LOGIC) begin
            if (op == EXE_OR_OP)  r = a | b;
            if (op == EXE_AND_OP) r = a & b;
            if (op == EXE_XOR_OP) r = a ^ b;
            if (op == EXE_NOR_OP) r = ~(a | b);
        end else if (sel == EXE_RES_SHIFT) begin
            if (op == EXE_SLL_OP) r = b << amt;
            if (op == EXE_SRL_OP) r = b >> amt;
            if (op == EXE_SRA_OP) begin
                r = b >> amt;
                if (b[31]) r = r | ~(32'hFFFF_FFFF >> amt);
            end
        end else if (sel == EXE_RES_ARITHMETIC) begin
            if (op == EXE_ADDU_OP) begin
                sum = longint'({32'h0, a}) + longint'({32'h0, b});
                r = sum[31:0];
            end
            if (op == EXE_SUBU_OP) begin
                sum = longint'({32'h0, a}) - longint'({32'h0, b});
                r = sum[31:0];
            end
            if (op == EXE_SLT_OP)  r = (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
            if (op == EXE_SLTU_OP) r = (longint'({32'h0, a}) < longint'({32'h0, b})) ? 32'd1 : 32'd0;
        end
        return r;
    endfunction

    // Reference divide: 64-bit arithmetic, so 0x80000000 / -1 simply wraps
    function automatic logic [63:0] model_div(input logic [7:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'h0) return 64'h0;
        if (op == EXE_DIV_OP) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'h0, a});
            sb = longint'({32'h0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Issue a divide at posedge+1, hold it while stalled, then check END.
    task automatic do_div(input string name, input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input int exp_stall);
        int stall_cnt   = 0;
        int whilo_early = 0;
        bit done        = 1'b0;
        drive(op, EXE_RES_NOP, a, b, 5'd2, 1'b1, 1'b0);
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (stallreq_o) begin
                stall_cnt++;
                if (whilo_o) whilo_early++;
            end else begin
                done = 1'b1;
            end
        end
        check({name, " completed"}, 32'(done), 32'd1);
        check({name, " stall cycles"}, stall_cnt, exp_stall);
        check({name, " whilo during stall"}, whilo_early, 32'd0);
        check({name, " whilo in END"}, 32'(whilo_o), 32'd1);
        check({name, " hi"}, hi_o, exp_hi);
        check({name, " lo"}, lo_o, exp_lo);
        @(posedge clk);
        #1;
    endtask

    logic [7:0] r_ops[11];
    logic [2:0] r_sels[11];

    initial begin
        logic [31:0] ra, rb, exp_w;
        logic [63:0] exp_d;
        logic [7:0]  dop;
        int          k;

        r_ops  = '{EXE_OR_OP, EXE_AND_OP, EXE_XOR_OP, EXE_NOR_OP, EXE_SLL_OP, EXE_SRL_OP,
                   EXE_SRA_OP, EXE_ADDU_OP, EXE_SUBU_OP, EXE_SLT_OP, EXE_SLTU_OP};
        r_sels = '{EXE_RES_LOGIC, EXE_RES_LOGIC, EXE_RES_LOGIC, EXE_RES_LOGIC, EXE_RES_SHIFT,
                   EXE_RES_SHIFT, EXE_RES_SHIFT, EXE_RES_ARITHMETIC, EXE_RES_ARITHMETIC,
                   EXE_RES_ARITHMETIC, EXE_RES_ARITHMETIC};

        //          name         op           sel                 a             b             wd     wr    an    exp_wdata     exp_wr exp_st
        vecs[0]  = '{"or",       EXE_OR_OP,   EXE_RES_LOGIC,      32'h0000FF00, 32'h00F0000F, 5'd3,  1'b1, 1'b0, 32'h00F0FF0F, 1'b1, 1'b0};
        vecs[1]  = '{"sra",      EXE_SRA_OP,  EXE_RES_SHIFT,      32'h00000004, 32'h80000010, 5'd4,  1'b1, 1'b0, 32'hF8000001, 1'b1, 1'b0};
        vecs[2]  = '{"slt",      EXE_SLT_OP,  EXE_RES_ARITHMETIC, 32'hFFFFFFFF, 32'h00000001, 5'd5,  1'b1, 1'b0, 32'h00000001, 1'b1, 1'b0};
        vecs[3]  = '{"sltu",     EXE_SLTU_OP, EXE_RES_ARITHMETIC, 32'hFFFFFFFF, 32'h00000001, 5'd6,  1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[4]  = '{"and",      EXE_AND_OP,  EXE_RES_LOGIC,      32'hF0F0F0F0, 32'h0FF00FF0, 5'd7,  1'b1, 1'b0, 32'h00F000F0, 1'b1, 1'b0};
        vecs[5]  = '{"xor",      EXE_XOR_OP,  EXE_RES_LOGIC,      32'hFFFF0000, 32'h0F0F0F0F, 5'd8,  1'b1, 1'b0, 32'hF0F00F0F, 1'b1, 1'b0};
        vecs[6]  = '{"nor",      EXE_NOR_OP,  EXE_RES_LOGIC,      32'h00000000, 32'h0000FFFF, 5'd9,  1'b1, 1'b0, 32'hFFFF0000, 1'b1, 1'b0};
        vecs[7]  = '{"sll31",    EXE_SLL_OP,  EXE_RES_SHIFT,      32'h0000001F, 32'h00000001, 5'd10, 1'b1, 1'b0, 32'h80000000, 1'b1, 1'b0};
        vecs[8]  = '{"sll_amt5", EXE_SLL_OP,  EXE_RES_SHIFT,      32'h00000023, 32'h00000001, 5'd11, 1'b1, 1'b0, 32'h00000008, 1'b1, 1'b0};
        vecs[9]  = '{"srl",      EXE_SRL_OP,  EXE_RES_SHIFT,      32'h00000004, 32'h80000010, 5'd12, 1'b1, 1'b0, 32'h08000001, 1'b1, 1'b0};
        vecs[10] = '{"addu_wrap",EXE_ADDU_OP, EXE_RES_ARITHMETIC, 32'hFFFFFFFF, 32'h00000002, 5'd13, 1'b1, 1'b0, 32'h00000001, 1'b1, 1'b0};
        vecs[11] = '{"subu_wrap",EXE_SUBU_OP, EXE_RES_ARITHMETIC, 32'h00000000, 32'h00000001, 5'd14, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[12] = '{"nop_class",EXE_OR_OP,   EXE_RES_NOP,        32'h12345678, 32'h9ABCDEF0, 5'd15, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[13] = '{"bad_op",   8'hEE,       EXE_RES_ARITHMETIC, 32'h12345678, 32'h9ABCDEF0, 5'd31, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0};
        vecs[14] = '{"divu_annul",EXE_DIVU_OP,EXE_RES_NOP,        32'd100,      32'd7,        5'd9,  1'b1, 1'b1, 32'h00000000, 1'b0, 1'b0};

        // ---- reset state: outputs held at 0 regardless of inputs ----
        drive(EXE_OR_OP, EXE_RES_LOGIC, 32'hFFFF0000, 32'h0000FFFF, 5'd17, 1'b1, 1'b0);
        #1;
        check("reset wdata", wdata_o, 32'h0);
        check("reset wd", 32'(wd_o), 32'h0);
        check("reset wreg", 32'(wreg_o), 32'h0);
        check("reset stall", 32'(stallreq_o), 32'h0);
        check("reset whilo", 32'(whilo_o), 32'h0);
        check("reset hi/lo", hi_o | lo_o, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // ---- table-driven combinational vectors ----
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].op, vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].wd, vecs[i].wreg, vecs[i].annul);
            @(negedge clk);
            check({vecs[i].name, " wdata"}, wdata_o, vecs[i].exp_wdata);
            check({vecs[i].name, " wd"}, 32'(wd_o), 32'(vecs[i].wd));
            check({vecs[i].name, " wreg"}, 32'(wreg_o), 32'(vecs[i].exp_wreg));
            check({vecs[i].name, " stall"}, 32'(stallreq_o), 32'(vecs[i].exp_stall));
            @(posedge clk);
            #1;
        end

        // ---- randomized ALU against the reference model ----
        for (int i = 0; i < 200; i++) begin
            k  = int'($urandom_range(0, 10));
            ra = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) rb = ra;
            exp_w = model_alu(r_ops[k], r_sels[k], ra, rb);
            drive(r_ops[k], r_sels[k], ra, rb, 5'($urandom_range(0, 31)), 1'b1, 1'b0);
            @(negedge clk);
            check($sformatf("rand%0d op%02h a%08h b%08h", i, r_ops[k], ra, rb), wdata_o, exp_w);
            @(posedge clk);
            #1;
        end

        // ---- divider sequences ----
        do_div("divu 100/7", EXE_DIVU_OP, 32'd100, 32'd7, 32'd2, 32'd14, 33);
        // back-to-back: next divide issued the cycle right after END
        do_div("div -7/2", EXE_DIV_OP, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
        do_div("div 5/0", EXE_DIV_OP, 32'd5, 32'd0, 32'h0, 32'h0, 2);
        do_div("div min/-1", EXE_DIV_OP, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33);
        drive(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("idle after div stall", 32'(stallreq_o), 32'h0);
        check("idle after div whilo", 32'(whilo_o), 32'h0);
        @(posedge clk);
        #1;

        // annul at iteration 10 of a DIVU, then the same op restarts from scratch
        drive(EXE_DIVU_OP, EXE_RES_NOP, 32'd100, 32'd7, 5'd2, 1'b1, 1'b0);
        repeat (11) @(posedge clk);
        #1;
        annul_i = 1'b1;
        #1;
        check("annul stall drops", 32'(stallreq_o), 32'h0);
        check("annul whilo", 32'(whilo_o), 32'h0);
        @(posedge clk);
        #1;
        do_div("divu after annul", EXE_DIVU_OP, 32'd100, 32'd7, 32'd2, 32'd14, 33);

        // asynchronous reset between edges in the middle of a divide
        drive(EXE_DIVU_OP, EXE_RES_NOP, 32'd500, 32'd3, 5'd7, 1'b1, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async rst stall", 32'(stallreq_o), 32'h0);
        check("async rst whilo", 32'(whilo_o), 32'h0);
        check("async rst wd", 32'(wd_o), 32'h0);
        check("async rst hi/lo", hi_o | lo_o, 32'h0);
        drive(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        do_div("divu after rst", EXE_DIVU_OP, 32'd1000, 32'd10, 32'd0, 32'd100, 33);

        // ---- randomized divides against the reference model ----
        for (int i = 0; i < 10; i++) begin
            dop = ($urandom_range(0, 1) == 0) ? EXE_DIV_OP : EXE_DIVU_OP;
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'($urandom_range(1, 15));
                1:       rb = ~32'($urandom_range(0, 15));
                2:       rb = 32'h0;
                default: rb = $urandom;
            endcase
            exp_d = model_div(dop, ra, rb);
            do_div($sformatf("rdiv%0d op%02h %08h/%08h", i, dop, ra, rb), dop, ra, rb,
                   exp_d[63:32], exp_d[31:0], (rb == 32'h0) ? 2 : 33);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
